// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: bundles the command stream, buffer config strobe, DMA monitor and status signals.
// Ports (slave = sequencer side):
//   cmd_data/cmd_valid/cmd_ready : command stream {opcode, mode, capture_len, arm_timeout}
//   trigger_in                   : level trigger
//   buf_cfg_data/buf_cfg_valid   : sample buffer config {mode, start, stop} with a one-cycle strobe
//   dma_valid/dma_ready/dma_last : monitored DMA output handshake
//   state_out/status_out/busy    : state encoding, {timeout_flag, abort_flag}, not-idle indicator
`timescale 1ns/1ps
interface capture_sequencer_if #(
    parameter int CHANNELS   = 8,
    parameter int LEN_WIDTH  = 32,
    parameter int MODE_WIDTH = $clog2($clog2(CHANNELS) + 1)
);
    logic [2+MODE_WIDTH+2*LEN_WIDTH-1:0] cmd_data;
    logic                                cmd_valid;
    logic                                cmd_ready;
    logic                                trigger_in;
    logic [MODE_WIDTH+1:0]               buf_cfg_data;
    logic                                buf_cfg_valid;
    logic                                dma_valid;
    logic                                dma_ready;
    logic                                dma_last;
    logic [2:0]                          state_out;
    logic [1:0]                          status_out;
    logic                                busy;
    modport master (
        output cmd_data, cmd_valid, trigger_in, dma_valid, dma_ready, dma_last,
        input  cmd_ready, buf_cfg_data, buf_cfg_valid, state_out, status_out, busy
    );
    modport slave (
        input  cmd_data, cmd_valid, trigger_in, dma_valid, dma_ready, dma_last,
        output cmd_ready, buf_cfg_data, buf_cfg_valid, state_out, status_out, busy
    );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: arms, triggers, times and reads out one RFADC capture per ARM command.
// Ports:
//   clk   : RFADC clock
//   reset : asynchronous active-low reset
//   bus   : capture_sequencer_if slave modport (command stream, trigger, buffer config, DMA monitor, status)
`timescale 1ns/1ps
module capture_sequencer #(
    parameter int CHANNELS   = 8,
    parameter int LEN_WIDTH  = 32,
    parameter int MODE_WIDTH = $clog2($clog2(CHANNELS) + 1)
) (
    input logic                clk,
    input logic                reset,
    capture_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        ARMED   = 3'd2,
        CAPTURE = 3'd3,
        STOP    = 3'd4,
        READOUT = 3'd5
    } state_t;
    state_t                state, nxt;
    logic [LEN_WIDTH-1:0]  cnt, cnt_nxt, len, timeout, beats_needed;
    logic [MODE_WIDTH-1:0] mode;
    logic                  timeout_flag, abort_flag, to_nxt, ab_nxt;
    logic                  cmd_ready, busy, cfg_valid;
    logic [MODE_WIDTH+1:0] cfg_data;
    logic [1:0]            opcode;
    logic [MODE_WIDTH-1:0] cmd_mode;
    logic [LEN_WIDTH-1:0]  cmd_len, cmd_timeout;
    logic                  fire, arm, abort, beat;
    assign {opcode, cmd_mode, cmd_len, cmd_timeout} = bus.cmd_data;
    assign fire  = bus.cmd_valid & cmd_ready;
    assign arm   = fire & (opcode == 2'b01);
    assign abort = fire & (opcode == 2'b10);
    assign beat  = bus.dma_valid & bus.dma_ready & bus.dma_last;
    // timestamp plus data buffer for each of the 1<<mode active banks
    assign beats_needed = LEN_WIDTH'(2) << mode;
    // one counter serves as ARMED cycle count, CAPTURE countdown and READOUT beat count
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        to_nxt  = timeout_flag;
        ab_nxt  = abort_flag;
        case (state)
            IDLE: if (arm) begin
                nxt    = START;
                to_nxt = 1'b0;
                ab_nxt = 1'b0;
            end
            START: begin
                nxt     = ARMED;
                cnt_nxt = '0;
            end
            ARMED: if (abort) begin
                nxt    = STOP;
                ab_nxt = 1'b1;
            end else if (bus.trigger_in) begin
                nxt     = CAPTURE;
                cnt_nxt = len;
            end else if (timeout != '0 && cnt == timeout - LEN_WIDTH'(1)) begin
                nxt    = STOP;
                to_nxt = 1'b1;
            end else
                cnt_nxt = cnt + LEN_WIDTH'(1);
            // a length of 0 or 1 both give a single capture cycle
            CAPTURE: if (abort) begin
                nxt    = STOP;
                ab_nxt = 1'b1;
            end else if (cnt <= LEN_WIDTH'(1))
                nxt = STOP;
            else
                cnt_nxt = cnt - LEN_WIDTH'(1);
            STOP: begin
                nxt     = (timeout_flag | abort_flag) ? IDLE : READOUT;
                cnt_nxt = '0;
            end
            READOUT: if (beat) begin
                nxt     = (cnt == beats_needed - LEN_WIDTH'(1)) ? IDLE : READOUT;
                cnt_nxt = (cnt == beats_needed - LEN_WIDTH'(1)) ? '0 : cnt + LEN_WIDTH'(1);
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= nxt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            mode         <= '0;
            len          <= '0;
            timeout      <= '0;
            timeout_flag <= 1'b0;
            abort_flag   <= 1'b0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            cfg_valid    <= 1'b0;
            cfg_data     <= '0;
        end else begin
            cnt          <= cnt_nxt;
            timeout_flag <= to_nxt;
            abort_flag   <= ab_nxt;
            if (state == IDLE && arm) begin
                mode    <= cmd_mode;
                len     <= cmd_len;
                timeout <= cmd_timeout;
            end
            cmd_ready <= nxt == IDLE || nxt == ARMED || nxt == CAPTURE;
            busy      <= nxt != IDLE;
            // strobe lands the cycle after START/STOP; data holds between strobes
            cfg_valid <= state == START || state == STOP;
            if (state == START || state == STOP) cfg_data <= {mode, state == START, state == STOP};
        end
    end
    assign bus.cmd_ready     = cmd_ready;
    assign bus.busy          = busy;
    assign bus.buf_cfg_valid = cfg_valid;
    assign bus.buf_cfg_data  = cfg_data;
    assign bus.state_out     = state;
    assign bus.status_out    = {timeout_flag, abort_flag};
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed table, hand sequences and randomized runs against a timeline model.
`timescale 1ns/1ps
module tb_capture_sequencer;
    localparam int LW = 32;
    localparam int MW = 2;
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_ARMED = 3'd2,
                           S_CAPTURE = 3'd3, S_STOP = 3'd4, S_READOUT = 3'd5;
    typedef struct {
        logic [1:0] mode;
        int         len;
        int         tmo;
        int         trig;
        int         abt;
        int         exp_a;
        int         exp_c;
        logic [1:0] exp_fl;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;
    logic [MW+1:0] last_cfg = '0;
    vec_t vecs[10];
    capture_sequencer_if #(.CHANNELS(8), .LEN_WIDTH(LW)) bus ();
    capture_sequencer #(.CHANNELS(8), .LEN_WIDTH(LW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Outcome of one capture from the command's rules: ARMED cycles, CAPTURE cycles, flags.
    function automatic void model(input vec_t v, output int a, output int c, output logic [1:0] fl);
        bit trig_ok;
        int arm_end;
        trig_ok = v.trig > 0 && (v.tmo == 0 || v.trig <= v.tmo);
        arm_end = trig_ok ? v.trig : v.tmo;
        c = 0;
        fl = 2'b00;
        if (v.abt > 0 && (arm_end == 0 || v.abt <= arm_end)) begin
            a = v.abt;
            fl = 2'b01;
        end else if (trig_ok) begin
            a = v.trig;
            c = v.len > 1 ? v.len : 1;
            if (v.abt > a && v.abt <= a + c) begin
                c = v.abt - a;
                fl = 2'b01;
            end
        end else begin
            a = v.tmo;
            fl = 2'b10;
        end
    endfunction
    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.state_out == S_IDLE && bus.cmd_ready) && k < 50);
        chk("idle_wait", {bus.state_out, bus.cmd_ready}, {S_IDLE, 1'b1});
    endtask
    task automatic noise_cmd(input bit no_abort);
        logic [95:0] r;
        logic [1:0] op;
        r = {$urandom(), $urandom(), $urandom()};
        op = 2'($urandom_range(0, 3));
        if (no_abort && op == 2'b10) op = 2'b11;
        bus.cmd_valid = r[95];
        bus.cmd_data = {op, r[65:0]};
    endtask
    task automatic run(input vec_t v);
        int a, c, j, beats, n;
        logic [1:0] fl;
        logic [2:0] es;
        logic [95:0] r;
        bit done;
        a = v.exp_a;
        c = v.exp_c;
        fl = v.exp_fl;
        n = 2 << v.mode;
        wait_idle();
        bus.cmd_data = {2'b01, v.mode, LW'(v.len), LW'(v.tmo)};
        bus.cmd_valid = 1'b1;
        bus.trigger_in = 1'b0;
        j = 0;
        beats = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            es = j == 0 ? S_START : j <= a ? S_ARMED : j <= a + c ? S_CAPTURE :
                 j == a + c + 1 ? S_STOP : (fl != 2'b00 || beats == n) ? S_IDLE : S_READOUT;
            if (j == 1) last_cfg = {v.mode, 2'b10};
            if (j == a + c + 2) last_cfg = {v.mode, 2'b01};
            chk("state", bus.state_out, es);
            chk("cfg_valid", bus.buf_cfg_valid, j == 1 || j == a + c + 2);
            chk("cfg_data", bus.buf_cfg_data, last_cfg);
            chk("cmd_ready", bus.cmd_ready, es == S_IDLE || es == S_ARMED || es == S_CAPTURE);
            chk("busy", bus.busy, es != S_IDLE);
            chk("status", bus.status_out, j > a + c ? fl : 2'b00);
            done = es == S_IDLE || j > 2000;
            bus.trigger_in = (j >= 1 && j <= a) ? (j == v.trig) : 1'($urandom);
            if (es == S_IDLE) bus.cmd_valid = 1'b0;
            else if (j >= 1 && j <= a + c && j == v.abt) begin
                r = {$urandom(), $urandom(), $urandom()};
                bus.cmd_valid = 1'b1;
                bus.cmd_data = {2'b10, r[65:0]};
            end else noise_cmd(j >= 1 && j <= a + c);
            bus.dma_valid = $urandom_range(0, 3) != 0;
            bus.dma_ready = $urandom_range(0, 3) != 0;
            bus.dma_last = $urandom_range(0, 3) != 0;
            if (es == S_READOUT && bus.dma_valid && bus.dma_ready && bus.dma_last) beats++;
            j++;
        end
    endtask
    initial begin
        vec_t v;
        int a, c, k;
        logic [1:0] fl;
        bus.cmd_valid = 1'b0;
        bus.cmd_data = '0;
        bus.trigger_in = 1'b0;
        bus.dma_valid = 1'b0;
        bus.dma_ready = 1'b0;
        bus.dma_last = 1'b0;
        // mode, len, timeout, trigger cycle, abort cycle -> ARMED cycles, CAPTURE cycles, {timeout,abort}
        vecs[0] = '{2'd0, 4, 0, 10, 0, 10, 4, 2'b00};
        vecs[1] = '{2'd0, 5, 8, 0, 0, 8, 0, 2'b10};
        vecs[2] = '{2'd1, 100, 0, 3, 8, 3, 5, 2'b01};
        vecs[3] = '{2'd3, 2, 0, 1, 0, 1, 2, 2'b00};
        vecs[4] = '{2'd2, 1, 5, 5, 0, 5, 1, 2'b00};
        vecs[5] = '{2'd0, 0, 0, 2, 0, 2, 1, 2'b00};
        vecs[6] = '{2'd1, 3, 0, 4, 4, 4, 0, 2'b01};
        vecs[7] = '{2'd2, 3, 0, 2, 5, 2, 3, 2'b01};
        vecs[8] = '{2'd1, 9, 6, 0, 6, 6, 0, 2'b01};
        vecs[9] = '{2'd3, 2, 1, 0, 0, 1, 0, 2'b10};
        repeat (3) @(negedge clk);
        chk("rst_state", bus.state_out, S_IDLE);
        chk("rst_cfg_valid", bus.buf_cfg_valid, 0);
        chk("rst_cfg_data", bus.buf_cfg_data, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_status", bus.status_out, 0);
        reset = 1'b1;
        #1 chk("ready_before_edge", bus.cmd_ready, 0);
        @(negedge clk);
        chk("ready_first_edge", bus.cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            bus.cmd_data = {i == 0 ? 2'b10 : i == 1 ? 2'b00 : 2'b11, 66'h1_2345_6789_abcd_ef01};
            bus.cmd_valid = 1'b1;
            @(negedge clk);
            chk("idle_ignore_state", bus.state_out, S_IDLE);
            chk("idle_ignore_status", bus.status_out, 0);
        end
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) run(vecs[i]);
        for (int i = 0; i < 40; i++) begin
            v.mode = 2'($urandom_range(0, 3));
            v.len = $urandom_range(0, 8);
            v.tmo = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 12);
            v.trig = $urandom_range(0, 14);
            v.abt = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 20);
            if (v.tmo == 0 && v.trig == 0 && v.abt == 0) v.trig = 1;
            model(v, a, c, fl);
            v.exp_a = a;
            v.exp_c = c;
            v.exp_fl = fl;
            run(v);
        end
        wait_idle();
        bus.cmd_data = {2'b01, 2'd3, LW'(1), LW'(0)};
        bus.cmd_valid = 1'b1;
        bus.trigger_in = 1'b1;
        bus.dma_valid = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (bus.state_out != S_READOUT && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("reach_readout", bus.state_out, S_READOUT);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", bus.state_out, S_IDLE);
        chk("arst_cfg_valid", bus.buf_cfg_valid, 0);
        chk("arst_cfg_data", bus.buf_cfg_data, 0);
        chk("arst_cmd_ready", bus.cmd_ready, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_status", bus.status_out, 0);
        repeat (3) begin
            @(negedge clk);
            chk("arst_hold_state", bus.state_out, S_IDLE);
            chk("arst_hold_valid", bus.buf_cfg_valid, 0);
        end
        reset = 1'b1;
        bus.trigger_in = 1'b0;
        last_cfg = '0;
        @(negedge clk);
        chk("arst_ready_after", bus.cmd_ready, 1);
        run(vecs[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, meaning the number of logical receive channels.
REQ-002 SHALL have parameter LEN_WIDTH, default 32, meaning the width of the capture-length and timeout counters.
REQ-003 SHALL have parameter MODE_WIDTH, default $clog2($clog2(CHANNELS)+1), meaning the width of the banking-mode field.
REQ-004 SHALL have port clk, input, 1 bit: the RFADC clock; one clock domain only.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_data, input, 2+MODE_WIDTH+2*LEN_WIDTH bits, packed {opcode[1:0], mode, capture_len, arm_timeout}.
  - opcode 01 = ARM; opcode 10 = ABORT; opcodes 00 and 11 are ignored.
REQ-007 SHALL have ports cmd_valid (input, 1 bit) and cmd_ready (output, 1 bit), forming an AXI-stream handshake.
REQ-008 SHALL have port trigger_in, input, 1 bit: a level trigger that starts capture.
REQ-009 SHALL have port buf_cfg_data, output, MODE_WIDTH+2 bits, packed {mode, start, stop}, driving the sample buffer config.
REQ-010 SHALL have port buf_cfg_valid, output, 1 bit: a single-cycle realtime strobe with no ready.
REQ-011 SHALL have ports dma_valid, dma_ready and dma_last, each input, 1 bit: monitored copies of the DMA output handshake.
REQ-012 SHALL have port state_out, output, 3 bits: the current state encoding.
REQ-013 SHALL have port status_out, output, 2 bits, packed {timeout_flag, abort_flag}.
REQ-014 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE=0, START=1, ARMED=2, CAPTURE=3, STOP=4, READOUT=5.
REQ-016 SHALL drive cmd_ready=1 in IDLE, ARMED and CAPTURE, and 0 in all other states.
REQ-017 SHALL, in IDLE, on an ARM handshake: latch mode, capture_len and arm_timeout, clear both status flags, and go to START.
REQ-018 SHALL ignore an ABORT handshake in IDLE; the command is consumed with no effect.
REQ-019 SHALL, in START, assert buf_cfg_valid for exactly one cycle with {mode,1,0}, then go to ARMED on the next cycle.
REQ-020 SHALL, in ARMED, count cycles.
  - trigger_in=1: go to CAPTURE and load the capture counter with capture_len.
  - Counter reaches arm_timeout before a trigger: set timeout_flag and go to STOP.
  - arm_timeout=0: no timeout; wait indefinitely.
REQ-021 SHALL, when trigger_in and the timeout occur on the same cycle, give the trigger priority.
REQ-022 SHALL, in CAPTURE, decrement the counter each cycle and go to STOP in the cycle the counter reaches 0.
  - capture_len=0 and capture_len=1 both yield exactly one CAPTURE cycle.
REQ-023 SHALL, in ARMED or CAPTURE, on an ABORT handshake: set abort_flag and go to STOP next cycle.
  - ABORT has priority over a same-cycle trigger or counter expiry.
REQ-024 SHALL ignore an ARM handshake in ARMED or CAPTURE; the command is consumed with no effect.
REQ-025 SHALL, in STOP, assert buf_cfg_valid for exactly one cycle with {mode,0,1}.
  - If timeout_flag or abort_flag is set: go to IDLE.
  - Otherwise: go to READOUT.
REQ-026 SHALL, in READOUT, count beats where dma_valid & dma_ready & dma_last.
  - Go to IDLE after 2*(1<<mode) such beats (timestamp plus data buffer per active bank).
REQ-027 SHALL compute the expected READOUT count at LEN_WIDTH width so that it never overflows.
REQ-028 SHALL register all outputs; buf_cfg_valid SHALL appear the cycle after entering START or STOP.
REQ-029 SHALL drive buf_cfg_valid=0 in all other cycles and hold buf_cfg_data at its last value.

Reset
REQ-030 SHALL, while reset=0, asynchronously force:
  - state = IDLE;
  - buf_cfg_valid=0 and buf_cfg_data=0;
  - cmd_ready=0, busy=0, status_out=0;
  - all counters and latched fields to 0.
REQ-031 SHALL drive cmd_ready=1 on the first clk edge after reset deasserts.
REQ-032 SHALL, on reset mid-capture, emit no stop strobe; the downstream buffer is reset by the same reset.

Verification
REQ-033 Nominal run: ARM(mode=0, len=4, timeout=0), trigger_in at cycle 10 -> SHALL produce:
  - start strobe {0,1,0};
  - exactly 4 CAPTURE cycles;
  - stop strobe {0,0,1};
  - return to IDLE after 2 dma_last beats.
REQ-034 Timeout: ARM(timeout=8), no trigger -> SHALL produce timeout_flag=1, a stop strobe 8 cycles after ARMED is entered, then IDLE with no READOUT.
REQ-035 Abort: ABORT during CAPTURE with len=100 -> SHALL produce abort_flag=1, a stop strobe the next cycle, then IDLE; the capture counter is discarded.
REQ-036 Mode 3: ARM(mode=3) -> SHALL remain in READOUT until exactly 16 dma_last beats.
  - dma_last beats with dma_ready=0 SHALL NOT count.
REQ-037 Ignored commands and priority:
  - ARM issued during ARMED -> no state change.
  - Trigger and timeout on the same cycle -> CAPTURE is entered.
REQ-038 Reset during READOUT (reset=0 for 3 cycles) -> all outputs SHALL be 0 immediately, with the state in IDLE.
